// File: rtl/edge_parameter_loader.sv
// Transmit end of the per-edge parameter chain: buffers one set of (weight, boundary) entries
// from a host stream and shifts it into the chain head during the parameter-loading stage.
module edge_parameter_loader #(
  parameter int unsigned NUM_LINKS         = 8,
  parameter int unsigned MAX_WEIGHT        = 2,
  parameter int unsigned HOST_WEIGHT_WIDTH = 4,
  parameter int unsigned STAGE_WIDTH       = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE               = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
  localparam int unsigned LINK_BIT_WIDTH   = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STAGE_WIDTH-1:0]       global_stage,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [HOST_WEIGHT_WIDTH-1:0] in_weight,
  input  logic [1:0]                   in_boundary,
  output logic [LINK_BIT_WIDTH-1:0]    weight_out,
  output logic [1:0]                   boundary_condition_out,
  output logic                         params_ready,
  output logic                         load_done,
  output logic                         underrun,
  output logic                         overrun
);

  localparam int unsigned CntW = $clog2(NUM_LINKS + 1);
  localparam int unsigned PtrW = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
  localparam logic [CntW-1:0] NumLinksCnt = CntW'(NUM_LINKS);
  localparam logic [CntW-1:0] LastCnt     = CntW'(NUM_LINKS - 1);
  localparam logic [PtrW-1:0] LastPtr     = PtrW'(NUM_LINKS - 1);
  localparam logic [HOST_WEIGHT_WIDTH-1:0] MaxWeightHost = HOST_WEIGHT_WIDTH'(MAX_WEIGHT);
  localparam logic [LINK_BIT_WIDTH-1:0]    MaxWeightLink = LINK_BIT_WIDTH'(MAX_WEIGHT);
  localparam logic [1:0] BoundaryNone       = 2'd0;
  localparam logic [1:0] BoundaryNonExistent = 2'd2;

  typedef enum logic [1:0] {StFill, StReady, StShift, StDone} state_e;

  state_e                   state_q;
  logic [STAGE_WIDTH-1:0]   stage_q;
  logic [CntW-1:0]          wr_cnt_q;
  logic [PtrW-1:0]          rd_ptr_q;
  logic                     loading_prev_q;

  logic [LINK_BIT_WIDTH-1:0] entry_w [NUM_LINKS];
  logic [1:0]                entry_b [NUM_LINKS];

  logic                      is_loading;
  logic                      shift_go;
  logic                      write_en;
  logic                      entry_valid;
  logic [PtrW-1:0]           wr_idx;
  logic [LINK_BIT_WIDTH-1:0] weight_clamped;

  always_comb begin
    is_loading = (stage_q == STAGE_PARAMETERS_LOADING);
    // In DONE, a loading stage that simply continues past the last shift is an overrun, not a
    // replay; only a fresh loading stage (previous cycle not loading) shifts again.
    shift_go = is_loading && ((state_q != StDone) || !loading_prev_q);
    in_ready = !is_loading &&
               (((state_q == StFill) && (wr_cnt_q < NumLinksCnt)) || (state_q == StDone));
    write_en = in_valid && in_ready;
    wr_idx   = (state_q == StDone) ? '0 : wr_cnt_q[PtrW-1:0];
    weight_clamped = (in_weight > MaxWeightHost) ? MaxWeightLink
                                                 : in_weight[LINK_BIT_WIDTH-1:0];
    entry_valid = (CntW'(rd_ptr_q) < wr_cnt_q);
    weight_out  = '0;
    boundary_condition_out = BoundaryNone;
    if (shift_go) begin
      weight_out             = entry_valid ? entry_w[rd_ptr_q] : '0;
      boundary_condition_out = entry_valid ? entry_b[rd_ptr_q] : BoundaryNonExistent;
    end
    params_ready = (wr_cnt_q == NumLinksCnt) || (state_q == StDone);
  end

  // Buffer contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      entry_w[wr_idx] <= weight_clamped;
      entry_b[wr_idx] <= in_boundary;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StFill;
      stage_q        <= STAGE_IDLE;
      wr_cnt_q       <= '0;
      rd_ptr_q       <= '0;
      loading_prev_q <= 1'b0;
      load_done      <= 1'b0;
      underrun       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      stage_q        <= global_stage;
      loading_prev_q <= is_loading;
      load_done      <= 1'b0;
      if (is_loading && (state_q == StDone) && loading_prev_q) begin
        overrun <= 1'b1;
      end
      if (shift_go) begin
        if (state_q == StFill) begin
          underrun <= 1'b1;
        end
        if (rd_ptr_q == LastPtr) begin
          rd_ptr_q  <= '0;
          load_done <= 1'b1;
          state_q   <= StDone;
        end else begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
          state_q  <= StShift;
        end
      end else begin
        unique case (state_q)
          StFill: begin
            if (write_en) begin
              wr_cnt_q <= wr_cnt_q + CntW'(1);
              if (wr_cnt_q == LastCnt) begin
                state_q <= StReady;
              end
            end
          end
          StReady: ;
          StShift: begin
            // Partial load abandoned; the next loading stage replays from entry 0.
            rd_ptr_q <= '0;
            state_q  <= (wr_cnt_q == NumLinksCnt) ? StReady : StFill;
          end
          StDone: begin
            if (write_en) begin
              wr_cnt_q <= CntW'(1);
              state_q  <= (NUM_LINKS == 1) ? StReady : StFill;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_parameter_loader.sv
// Randomized self-checking bench for edge_parameter_loader against a set-level reference model.
module tb_edge_parameter_loader;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXW = 2;
  localparam int unsigned HW   = 4;
  localparam int unsigned SW   = 3;
  localparam int unsigned LW   = 2;
  localparam logic [SW-1:0] ST_IDLE = 3'd0;
  localparam logic [SW-1:0] ST_LOAD = 3'd1;

  logic          clk;
  logic          reset;
  logic [SW-1:0] global_stage;
  logic          in_valid;
  logic          in_ready;
  logic [HW-1:0] in_weight;
  logic [1:0]    in_boundary;
  logic [LW-1:0] weight_out;
  logic [1:0]    boundary_condition_out;
  logic          params_ready;
  logic          load_done;
  logic          underrun;
  logic          overrun;

  edge_parameter_loader #(
    .NUM_LINKS               (N),
    .MAX_WEIGHT              (MAXW),
    .HOST_WEIGHT_WIDTH       (HW),
    .STAGE_WIDTH             (SW),
    .STAGE_IDLE              (ST_IDLE),
    .STAGE_PARAMETERS_LOADING(ST_LOAD)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .global_stage          (global_stage),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_weight             (in_weight),
    .in_boundary           (in_boundary),
    .weight_out            (weight_out),
    .boundary_condition_out(boundary_condition_out),
    .params_ready          (params_ready),
    .load_done             (load_done),
    .underrun              (underrun),
    .overrun               (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the set the loader should currently hold, in host order.
  int set_w[N];
  int set_b[N];
  int set_n = 0;

  int rec_w[16];
  int rec_b[16];
  int rec_done[16];
  int rec_rdy[16];

  // Cycle i of a loading stage of length len sends entry i (padded past set_n), nothing past N.
  function automatic int exp_w(int i, int len);
    if (i < len && i < N) return (i < set_n) ? set_w[i] : 0;
    return 0;
  endfunction

  function automatic int exp_b(int i, int len);
    if (i < len && i < N) return (i < set_n) ? set_b[i] : 2;
    return 0;
  endfunction

  function automatic int exp_done(int i, int len);
    return (len >= N && i == N) ? 1 : 0;
  endfunction

  task automatic model_push(input int w, input int b);
    set_w[set_n] = (w > MAXW) ? MAXW : w;
    set_b[set_n] = b;
    set_n++;
  endtask

  task automatic write_entry(input int w, input int b);
    bit ok = 1'b0;
    in_valid    = 1'b1;
    in_weight   = HW'(w);
    in_boundary = 2'(b);
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL write_accept: in_ready got 0, required 1 within 20 cycles");
    end else begin
      model_push(w, b);
    end
  endtask

  // Holds loading for len cycles then two idle cycles, recording outputs each cycle.
  task automatic load_cycles(input int len);
    for (int i = 0; i < len + 2; i++) begin
      global_stage = (i < len) ? ST_LOAD : ST_IDLE;
      @(posedge clk); #1;
      rec_w[i]    = int'(weight_out);
      rec_b[i]    = int'(boundary_condition_out);
      rec_done[i] = int'(load_done);
      rec_rdy[i]  = int'(in_ready);
    end
    global_stage = ST_IDLE;
  endtask

  task automatic test_reset();
    reset = 1'b0; global_stage = ST_IDLE; in_valid = 1'b0; in_weight = '0; in_boundary = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || params_ready !== 1'b0 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b pr=%b ld=%b, required 1 0 0",
               in_ready, params_ready, load_done);
    end
    n_checks++;
    if (weight_out !== 2'd0 || boundary_condition_out !== 2'd0 || underrun !== 1'b0 ||
        overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got w=%0d b=%0d ur=%b or=%b, required 0 0 0 0",
               weight_out, boundary_condition_out, underrun, overrun);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || params_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b pr=%b, required 1 0", in_ready, params_ready);
    end
  endtask

  task automatic test_fill_and_load();
    set_n = 0;
    write_entry(1, 0); write_entry(2, 1); write_entry(0, 2); write_entry(2, 3);
    n_checks++;
    if (params_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got pr=%b rdy=%b, required 1 0", params_ready, in_ready);
    end
    load_cycles(4);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 4) || rec_b[i] !== exp_b(i, 4) ||
          rec_done[i] !== exp_done(i, 4)) begin
        n_fail++;
        $display("FAIL fill_load[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 4), exp_b(i, 4), exp_done(i, 4));
      end
    end
    n_checks++;
    if (underrun !== 1'b0 || overrun !== 1'b0 || params_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_flags: got ur=%b or=%b pr=%b, required 0 0 1",
               underrun, overrun, params_ready);
    end
  endtask

  task automatic test_clamp();
    int pos = int'($urandom_range(0, N - 1));
    set_n = 0;
    for (int k = 0; k < N; k++) begin
      write_entry((k == pos) ? 7 : int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if (k == 0) begin
        n_checks++;
        if (params_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL clamp_newset: params_ready got %b, required 0", params_ready);
        end
      end
    end
    load_cycles(4);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 4) || rec_b[i] !== exp_b(i, 4) ||
          rec_done[i] !== exp_done(i, 4)) begin
        n_fail++;
        $display("FAIL clamp_load[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 4), exp_b(i, 4), exp_done(i, 4));
      end
    end
    n_checks++;
    if (rec_w[pos] !== 2) begin
      n_fail++;
      $display("FAIL clamp_value: weight got %0d, required 2", rec_w[pos]);
    end
  endtask

  task automatic test_early_abort();
    set_n = 0;
    for (int k = 0; k < N; k++) write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    load_cycles(2);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 2) || rec_b[i] !== exp_b(i, 2) || rec_done[i] !== 0) begin
        n_fail++;
        $display("FAIL abort_partial[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d 0", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 2), exp_b(i, 2));
      end
    end
    n_checks++;
    if (params_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got pr=%b rdy=%b, required 1 0", params_ready, in_ready);
    end
    load_cycles(4);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 4) || rec_b[i] !== exp_b(i, 4) ||
          rec_done[i] !== exp_done(i, 4)) begin
        n_fail++;
        $display("FAIL abort_replay[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 4), exp_b(i, 4), exp_done(i, 4));
      end
    end
  endtask

  task automatic test_overrun_backpressure();
    set_n = 0;
    for (int k = 0; k < N; k++) write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    in_valid = 1'b1; in_weight = 4'd1; in_boundary = 2'd0;
    for (int t = 0; t < 3; t++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_full[%0d]: in_ready got %b, required 0", t, in_ready);
      end
      @(posedge clk); #1;
    end
    load_cycles(5);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 5) || rec_b[i] !== exp_b(i, 5) ||
          rec_done[i] !== exp_done(i, 5) || rec_rdy[i] !== ((i < 5) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL overrun_load[%0d]: got w=%0d b=%0d done=%0d rdy=%0d, required %0d %0d %0d %0d",
                 i, rec_w[i], rec_b[i], rec_done[i], rec_rdy[i], exp_w(i, 5), exp_b(i, 5),
                 exp_done(i, 5), (i < 5) ? 0 : 1);
      end
    end
    // The held write is accepted once DONE is reached and starts a new set.
    set_n = 0;
    model_push(1, 0);
    n_checks++;
    if (overrun !== 1'b1 || underrun !== 1'b0 || params_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_flags: got or=%b ur=%b pr=%b, required 1 0 0",
               overrun, underrun, params_ready);
    end
  endtask

  task automatic test_underrun();
    write_entry(1, 0);
    load_cycles(4);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 4) || rec_b[i] !== exp_b(i, 4) ||
          rec_done[i] !== exp_done(i, 4)) begin
        n_fail++;
        $display("FAIL underrun_load[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 4), exp_b(i, 4), exp_done(i, 4));
      end
    end
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_flag: got %b, required 1", underrun);
    end
  endtask

  task automatic test_async_reset();
    set_n = 0;
    for (int k = 0; k < N; k++) write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    global_stage = ST_LOAD;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (int'(weight_out) !== set_w[2] || int'(boundary_condition_out) !== set_b[2]) begin
      n_fail++;
      $display("FAIL areset_pre: got w=%0d b=%0d, required %0d %0d",
               weight_out, boundary_condition_out, set_w[2], set_b[2]);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (weight_out !== 2'd0 || boundary_condition_out !== 2'd0 || in_ready !== 1'b1 ||
        underrun !== 1'b0 || overrun !== 1'b0 || params_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got w=%0d b=%0d rdy=%b ur=%b or=%b pr=%b, required 0 0 1 0 0 0",
               weight_out, boundary_condition_out, in_ready, underrun, overrun, params_ready);
    end
    global_stage = ST_IDLE;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    set_n = 0;
    for (int k = 0; k < N - 1; k++) write_entry(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    n_checks++;
    if (params_ready !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_count: got pr=%b rdy=%b, required 0 1", params_ready, in_ready);
    end
    write_entry(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    n_checks++;
    if (params_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_full: params_ready got %b, required 1", params_ready);
    end
    load_cycles(4);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (rec_w[i] !== exp_w(i, 4) || rec_b[i] !== exp_b(i, 4) ||
          rec_done[i] !== exp_done(i, 4)) begin
        n_fail++;
        $display("FAIL areset_load[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d", i,
                 rec_w[i], rec_b[i], rec_done[i], exp_w(i, 4), exp_b(i, 4), exp_done(i, 4));
      end
    end
  endtask

  task automatic test_random_sets();
    for (int it = 0; it < 4; it++) begin
      int len = int'($urandom_range(1, 6));
      set_n = 0;
      for (int k = 0; k < N; k++) write_entry(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      load_cycles(len);
      for (int i = 0; i < len + 2; i++) begin
        n_checks++;
        if (rec_w[i] !== exp_w(i, len) || rec_b[i] !== exp_b(i, len) ||
            rec_done[i] !== exp_done(i, len)) begin
          n_fail++;
          $display("FAIL rand%0d_len%0d[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d",
                   it, len, i, rec_w[i], rec_b[i], rec_done[i], exp_w(i, len), exp_b(i, len),
                   exp_done(i, len));
        end
      end
      if (len < N) begin
        load_cycles(N);
        for (int i = 0; i < N + 2; i++) begin
          n_checks++;
          if (rec_w[i] !== exp_w(i, N) || rec_b[i] !== exp_b(i, N) ||
              rec_done[i] !== exp_done(i, N)) begin
            n_fail++;
            $display("FAIL rand%0d_replay[%0d]: got w=%0d b=%0d done=%0d, required %0d %0d %0d",
                     it, i, rec_w[i], rec_b[i], rec_done[i], exp_w(i, N), exp_b(i, N),
                     exp_done(i, N));
          end
        end
      end
    end
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_underrun: got %b, required 0", underrun);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_and_load();
    test_clamp();
    test_early_abort();
    test_overrun_backpressure();
    test_underrun();
    test_async_reset();
    test_random_sets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
